// File: rtl/cpu_defs.sv
// Shared opcode map, instruction field layout and sequencer state encoding for the 8-bit CPU.
package cpu_defs;

  localparam logic [4:0] OP_LOAD    = 5'b00000;
  localparam logic [4:0] OP_LDI     = 5'b00001;
  localparam logic [4:0] OP_MOV     = 5'b00010;
  localparam logic [4:0] OP_STORE   = 5'b00011;
  localparam logic [4:0] OP_ALU_MIN = 5'b00100;
  localparam logic [4:0] OP_ALU_MAX = 5'b01101;
  localparam logic [4:0] OP_JMP     = 5'b01110;
  localparam logic [4:0] OP_JZ      = 5'b01111;
  localparam logic [4:0] OP_HALT    = 5'b11111;

  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 11;
  localparam int unsigned RD_MSB  = 10;
  localparam int unsigned RD_LSB  = 8;
  localparam int unsigned IMM_MSB = 7;
  localparam int unsigned IMM_LSB = 0;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StHalt
  } state_e;

  typedef struct packed {
    logic is_write;
    logic is_mem;
    logic is_alu;
    logic is_branch;
    logic is_halt;
  } op_class_t;

endpackage

// File: rtl/decod_instr.sv
// Combinational opcode classifier used by the sequencer for next-state selection.
module decod_instr
  import cpu_defs::*;
#(
  parameter logic [4:0] HALT_OP = OP_HALT
) (
  input  logic [4:0] opcode,
  output op_class_t  cls
);

  logic alu_range;

  always_comb begin
    alu_range     = (opcode >= OP_ALU_MIN) && (opcode <= OP_ALU_MAX);
    cls           = '0;
    cls.is_alu    = alu_range;
    cls.is_mem    = (opcode == OP_LOAD) || (opcode == OP_STORE);
    cls.is_branch = (opcode == OP_JMP) || (opcode == OP_JZ);
    cls.is_halt   = (opcode == HALT_OP);
    // LOAD counts as a write: it reaches WB after the memory phase.
    cls.is_write  = (opcode == OP_LOAD) || (opcode == OP_LDI) || (opcode == OP_MOV) || alu_range;
  end

endmodule

// File: rtl/unidade_controle.sv
// Multicycle control unit: fetch, decode, execute, memory and writeback sequencing.
module unidade_controle
  import cpu_defs::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 16,
  parameter logic [4:0]  HALT_OP = 5'b11111
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               dmem_re,
  output logic               dmem_we,
  output logic [ADDR_W-1:0]  dmem_addr,
  input  logic               dmem_ack,
  input  logic               alu_zero,
  output logic [4:0]         opcode,
  output logic [2:0]         rd,
  output logic [7:0]         imm,
  output logic               reg_we,
  output logic               alu_en,
  output logic               halted,
  output logic [ADDR_W-1:0]  pc
);

  state_e             state;
  logic [INSTR_W-1:0] ir;
  logic [4:0]         ir_op;
  op_class_t          cls;

  // ir holds the current instruction from DECODE through WB, so classifying it
  // is valid in every state that makes a decision.
  assign ir_op     = ir[OPC_MSB:OPC_LSB];
  assign imem_addr = pc;
  assign dmem_addr = ADDR_W'(imm);

  decod_instr #(
    .HALT_OP(HALT_OP)
  ) u_decod_instr (
    .opcode(ir_op),
    .cls   (cls)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= StFetch;
      pc       <= '0;
      ir       <= '0;
      opcode   <= '0;
      rd       <= '0;
      imm      <= '0;
      imem_req <= 1'b0;
      dmem_re  <= 1'b0;
      dmem_we  <= 1'b0;
      reg_we   <= 1'b0;
      alu_en   <= 1'b0;
      halted   <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      alu_en <= 1'b0;
      unique case (state)
        StFetch: begin
          if (imem_req && imem_ack) begin
            ir       <= imem_data;
            pc       <= pc + ADDR_W'(1);
            imem_req <= 1'b0;
            state    <= StDecode;
          end else begin
            imem_req <= 1'b1;
          end
        end
        StDecode: begin
          opcode <= ir[OPC_MSB:OPC_LSB];
          rd     <= ir[RD_MSB:RD_LSB];
          imm    <= ir[IMM_MSB:IMM_LSB];
          if (cls.is_halt) begin
            halted <= 1'b1;
            state  <= StHalt;
          end else begin
            alu_en <= cls.is_alu;
            state  <= StExec;
          end
        end
        StExec: begin
          if (cls.is_branch && ((ir_op == OP_JMP) || alu_zero)) begin
            pc <= ADDR_W'(imm);
          end
          if (cls.is_mem) begin
            dmem_re <= cls.is_write;
            dmem_we <= !cls.is_write;
            state   <= StMem;
          end else if (cls.is_write) begin
            reg_we <= 1'b1;
            state  <= StWb;
          end else begin
            imem_req <= 1'b1;
            state    <= StFetch;
          end
        end
        StMem: begin
          if (dmem_ack) begin
            dmem_re <= 1'b0;
            dmem_we <= 1'b0;
            if (cls.is_write) begin
              reg_we <= 1'b1;
              state  <= StWb;
            end else begin
              imem_req <= 1'b1;
              state    <= StFetch;
            end
          end
        end
        StWb: begin
          imem_req <= 1'b1;
          state    <= StFetch;
        end
        StHalt: begin
          halted <= 1'b1;
        end
        default: state <= StFetch;
      endcase
    end
  end

endmodule

// File: tb/tb_unidade_controle.sv
// Scenario bench for unidade_controle with a writeback scoreboard.
module tb_unidade_controle;

  typedef struct packed {
    logic [4:0] op;
    logic [2:0] rd;
    logic [7:0] imm;
  } wb_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_data = '0;
  logic        dmem_re;
  logic        dmem_we;
  logic [7:0]  dmem_addr;
  logic        dmem_ack = 1'b0;
  logic        alu_zero = 1'b0;
  logic [4:0]  opcode;
  logic [2:0]  rd;
  logic [7:0]  imm;
  logic        reg_we;
  logic        alu_en;
  logic        halted;
  logic [7:0]  pc;

  int  n_cmp  = 0;
  int  n_fail = 0;
  wb_t sb[$];

  unidade_controle dut (
    .clk      (clk),
    .rst      (rst),
    .imem_req (imem_req),
    .imem_addr(imem_addr),
    .imem_ack (imem_ack),
    .imem_data(imem_data),
    .dmem_re  (dmem_re),
    .dmem_we  (dmem_we),
    .dmem_addr(dmem_addr),
    .dmem_ack (dmem_ack),
    .alu_zero (alu_zero),
    .opcode   (opcode),
    .rd       (rd),
    .imm      (imm),
    .reg_we   (reg_we),
    .alu_en   (alu_en),
    .halted   (halted),
    .pc       (pc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded, got running want finished");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every reg_we pulse must match the oldest expected writeback.
  always @(negedge clk) begin
    if (rst && reg_we) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_we: got reg_we op=%b rd=%0d imm=%h want none", opcode, rd, imm);
      end else begin
        wb_t e;
        e = sb.pop_front();
        if ({opcode, rd, imm} !== e) begin
          n_fail++;
          $display("FAIL sb_wb: got op=%b rd=%0d imm=%h want op=%b rd=%0d imm=%h",
                   opcode, rd, imm, e.op, e.rd, e.imm);
        end
      end
    end
  end

  // Waits (bounded) for a fetch request, checks its address, then acks after dly cycles.
  task automatic serve_fetch(input logic [15:0] instr, input int dly, input logic [7:0] exp_pc);
    int n = 0;
    while (imem_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL fetch_timeout: got imem_req=%b want 1", imem_req);
    end
    n_cmp++;
    if (imem_addr !== exp_pc) begin
      n_fail++;
      $display("FAIL fetch_addr: got %h want %h", imem_addr, exp_pc);
    end
    repeat (dly) @(negedge clk);
    imem_data = instr;
    imem_ack  = 1'b1;
    @(negedge clk);
    imem_ack  = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({imem_req, dmem_re, dmem_we, reg_we, alu_en, halted} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b want 000000",
               {imem_req, dmem_re, dmem_we, reg_we, alu_en, halted});
    end
    n_cmp++;
    if ({pc, opcode, rd, imm} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_regs: got pc=%h op=%b rd=%0d imm=%h want all 0", pc, opcode, rd, imm);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ldi();
    sb.push_back('{op: 5'b00001, rd: 3'd1, imm: 8'h05});
    serve_fetch(16'h0905, 0, 8'h00);
    n_cmp++;
    if (pc !== 8'h01) begin
      n_fail++;
      $display("FAIL ldi_pc: got %h want 01", pc);
    end
    @(negedge clk);
    n_cmp++;
    if (reg_we !== 1'b0 || alu_en !== 1'b0) begin
      n_fail++;
      $display("FAIL ldi_exec: got reg_we=%b alu_en=%b want 0 0", reg_we, alu_en);
    end
    @(negedge clk);
    n_cmp++;
    if (reg_we !== 1'b1 || opcode !== 5'b00001 || rd !== 3'd1 || imm !== 8'h05) begin
      n_fail++;
      $display("FAIL ldi_wb: got we=%b op=%b rd=%0d imm=%h want 1 00001 1 05", reg_we, opcode, rd, imm);
    end
    @(negedge clk);
  endtask

  task automatic test_load_wait();
    sb.push_back('{op: 5'b00000, rd: 3'd2, imm: 8'h10});
    serve_fetch(16'h0210, 0, 8'h01);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (dmem_re !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 8'h10 || reg_we !== 1'b0) begin
        n_fail++;
        $display("FAIL load_wait%0d: got re=%b we=%b addr=%h reg_we=%b want 1 0 10 0",
                 i, dmem_re, dmem_we, dmem_addr, reg_we);
      end
      if (i == 2) dmem_ack = 1'b1;
      @(negedge clk);
    end
    dmem_ack = 1'b0;
    n_cmp++;
    if (reg_we !== 1'b1 || dmem_re !== 1'b0) begin
      n_fail++;
      $display("FAIL load_wb: got reg_we=%b dmem_re=%b want 1 0", reg_we, dmem_re);
    end
    @(negedge clk);
  endtask

  task automatic test_store_alu();
    serve_fetch(16'h1B20, 0, 8'h02);
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (dmem_we !== 1'b1 || dmem_re !== 1'b0 || dmem_addr !== 8'h20) begin
      n_fail++;
      $display("FAIL store_mem: got we=%b re=%b addr=%h want 1 0 20", dmem_we, dmem_re, dmem_addr);
    end
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    n_cmp++;
    if (reg_we !== 1'b0 || dmem_we !== 1'b0 || imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL store_done: got reg_we=%b dmem_we=%b imem_req=%b want 0 0 1",
               reg_we, dmem_we, imem_req);
    end
    sb.push_back('{op: 5'b00100, rd: 3'd4, imm: 8'h00});
    serve_fetch(16'h2400, 0, 8'h03);
    n_cmp++;
    if (alu_en !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_decode: got alu_en=%b want 0", alu_en);
    end
    @(negedge clk);
    n_cmp++;
    if (alu_en !== 1'b1 || reg_we !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_exec: got alu_en=%b reg_we=%b want 1 0", alu_en, reg_we);
    end
    @(negedge clk);
    n_cmp++;
    if (alu_en !== 1'b0 || reg_we !== 1'b1) begin
      n_fail++;
      $display("FAIL alu_wb: got alu_en=%b reg_we=%b want 0 1", alu_en, reg_we);
    end
    @(negedge clk);
  endtask

  task automatic test_jz();
    alu_zero = 1'b1;
    serve_fetch(16'h7840, 0, 8'h04);
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (pc !== 8'h40 || imem_addr !== 8'h40) begin
      n_fail++;
      $display("FAIL jz_taken: got pc=%h imem_addr=%h want 40 40", pc, imem_addr);
    end
    alu_zero = 1'b0;
    serve_fetch(16'h7840, 1, 8'h40);
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (pc !== 8'h41 || imem_addr !== 8'h41) begin
      n_fail++;
      $display("FAIL jz_not_taken: got pc=%h imem_addr=%h want 41 41", pc, imem_addr);
    end
  endtask

  task automatic test_wrap_halt();
    serve_fetch(16'h70FF, 0, 8'h41);
    @(negedge clk);
    @(negedge clk);
    serve_fetch(16'h8000, 0, 8'hFF);
    n_cmp++;
    if (pc !== 8'h00) begin
      n_fail++;
      $display("FAIL pc_wrap: got %h want 00", pc);
    end
    @(negedge clk);
    @(negedge clk);
    serve_fetch(16'hF800, 0, 8'h00);
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      imem_ack = i[0];
      n_cmp++;
      if (halted !== 1'b1 || imem_req !== 1'b0 || alu_en !== 1'b0 || dmem_re !== 1'b0) begin
        n_fail++;
        $display("FAIL halt%0d: got halted=%b imem_req=%b alu_en=%b dmem_re=%b want 1 0 0 0",
                 i, halted, imem_req, alu_en, dmem_re);
      end
      @(negedge clk);
    end
    imem_ack = 1'b0;
  endtask

  task automatic test_reset_mid_mem();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    serve_fetch(16'h0210, 0, 8'h00);
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (dmem_re !== 1'b1) begin
      n_fail++;
      $display("FAIL rmem_pre: got dmem_re=%b want 1", dmem_re);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (dmem_re !== 1'b0 || pc !== 8'h00 || imem_req !== 1'b0 || reg_we !== 1'b0) begin
      n_fail++;
      $display("FAIL rmem_async: got re=%b pc=%h imem_req=%b reg_we=%b want 0 00 0 0",
               dmem_re, pc, imem_req, reg_we);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h00 || reg_we !== 1'b0) begin
      n_fail++;
      $display("FAIL rmem_refetch: got imem_req=%b addr=%h reg_we=%b want 1 00 0",
               imem_req, imem_addr, reg_we);
    end
  endtask

  initial begin
    test_reset();
    test_ldi();
    test_load_wait();
    test_store_alu();
    test_jz();
    test_wrap_halt();
    test_reset_mid_mem();
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending writebacks want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
